fetch_unit: RTL and testbench

- Instruction-fetch stage directly downstream of the program counter register.
- Takes the current PC value, issues in-order requests to instruction memory over a valid/ready handshake, and drives the PC's write-enable and next address (PC+4).
- Buffers returned instructions with their addresses in a small FIFO and presents them to decode with a valid/ready handshake.
- Supports flush on redirect (branch/jump), discarding any stale in-flight responses.

---
 rtl/fetch_unit.sv | 134 +++++++++++++
 tb/tb_fetch_unit.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues in-order PC fetches under a credit limit,
// buffers {instr, pc} pairs for decode, and drops stale responses after a redirect.
module fetch_unit #(
  parameter int DEPTH = 2,
  parameter int CNT_W = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_in,
  output logic        pc_write,
  output logic [31:0] next_pc,
  input  logic        flush,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  input  logic        id_ready,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic        fetch_err
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W:0] DEPTH_C = (CNT_W+1)'(DEPTH);

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } ent_t;

  ent_t              fifo_q [DEPTH];
  ent_t              fifo_d [DEPTH];
  logic [31:0]       aq_q   [DEPTH];
  logic [31:0]       aq_d   [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  aq_wr_q, aq_wr_d, aq_rd_q, aq_rd_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [CNT_W-1:0]  out_q, out_d;
  logic [CNT_W-1:0]  disc_q, disc_d;
  logic              err_q, err_d;

  logic fire, rsp_ok, rsp_drop, push, pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH-1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Credit covers buffered entries plus every in-flight request, stale ones included.
  assign imem_req_valid = reset && !flush &&
                          (({1'b0, count_q} + {1'b0, out_q}) < DEPTH_C);
  assign imem_addr = pc_in;
  assign fire      = imem_req_valid && imem_req_ready;
  assign pc_write  = fire;
  assign next_pc   = pc_in + 32'd4;

  assign rsp_ok   = imem_rsp_valid && (out_q != '0);
  assign rsp_drop = rsp_ok && (disc_q != '0);
  assign push     = rsp_ok && (disc_q == '0) && !flush;
  assign pop      = (count_q != '0) && id_ready && !flush;

  assign if_valid  = (count_q != '0);
  assign if_instr  = fifo_q[rd_ptr_q].instr;
  assign if_pc     = fifo_q[rd_ptr_q].pc;
  assign fetch_err = err_q;

  always_comb begin
    fifo_d   = fifo_q;
    aq_d     = aq_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    aq_wr_d  = aq_wr_q;
    aq_rd_d  = aq_rd_q;
    count_d  = count_q;
    out_d    = out_q;
    disc_d   = disc_q;
    err_d    = err_q || (imem_rsp_valid && (out_q == '0));

    if (flush) begin
      // Existing discards are already part of out_q, so everything still in
      // flight after this edge becomes a discard.
      disc_d   = out_q - CNT_W'(rsp_ok);
      out_d    = out_q - CNT_W'(rsp_ok);
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      aq_wr_d  = '0;
      aq_rd_d  = '0;
    end else begin
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
      out_d   = out_q + CNT_W'(fire) - CNT_W'(rsp_ok);
      disc_d  = disc_q - CNT_W'(rsp_drop);
      if (fire) begin
        aq_d[aq_wr_q] = pc_in;
        aq_wr_d       = ptr_inc(aq_wr_q);
      end
      // Stale responses are not in the address queue, so only kept ones pop it.
      if (push) begin
        fifo_d[wr_ptr_q] = '{instr: imem_rdata, pc: aq_q[aq_rd_q]};
        wr_ptr_d         = ptr_inc(wr_ptr_q);
        aq_rd_d          = ptr_inc(aq_rd_q);
      end
      if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fifo_q   <= '{default: '0};
      aq_q     <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      aq_wr_q  <= '0;
      aq_rd_q  <= '0;
      count_q  <= '0;
      out_q    <= '0;
      disc_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      fifo_q   <= fifo_d;
      aq_q     <= aq_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      aq_wr_q  <= aq_wr_d;
      aq_rd_q  <= aq_rd_d;
      count_q  <= count_d;
      out_q    <= out_d;
      disc_q   <= disc_d;
      err_q    <= err_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized scoreboard bench for fetch_unit: a transaction-level memory/PC model
// predicts issue, delivery order, flush drops and fetch_err.
module tb_fetch_unit;
  localparam int DEPTH = 2;

  logic        clk = 1'b0, reset = 1'b0;
  logic [31:0] pc_in = '0;
  logic        pc_write;
  logic [31:0] next_pc;
  logic        flush = 1'b0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        if_valid;
  logic        id_ready = 1'b0;
  logic [31:0] if_instr, if_pc;
  logic        fetch_err;

  fetch_unit #(.DEPTH(DEPTH), .CNT_W(2)) dut (
    .clk(clk), .reset(reset), .pc_in(pc_in), .pc_write(pc_write), .next_pc(next_pc),
    .flush(flush), .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_addr(imem_addr), .imem_rsp_valid(imem_rsp_valid), .imem_rdata(imem_rdata),
    .if_valid(if_valid), .id_ready(id_ready), .if_instr(if_instr), .if_pc(if_pc),
    .fetch_err(fetch_err)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; int due; bit stale; } req_t;
  typedef struct { logic [31:0] pc; logic [31:0] instr; } exp_t;

  req_t mem_q[$];
  exp_t exp_q[$];
  int total = 0, bad = 0, cyc = 0, buf_cnt = 0, last_due = 0;
  bit model_err = 0, mon_en = 0, spur = 0;
  int p_ready = 100, p_idr = 100, p_flush = 0, lat_max = 1;
  logic [31:0] pc_nxt = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return a + 32'h1000;
  endfunction

  // Monitor: compares the decode-side head against the scoreboard and pops on handshake.
  always @(negedge clk) begin
    #1;
    if (mon_en) begin
      chk("if_valid", 32'(if_valid), 32'(exp_q.size() != 0));
      if (if_valid && exp_q.size() != 0) begin
        chk("if_pc", if_pc, exp_q[0].pc);
        chk("if_instr", if_instr, exp_q[0].instr);
        if (id_ready && !flush) void'(exp_q.pop_front());
      end
    end
  end

  task automatic step();
    bit exp_rv, exp_fire, push, pop;
    req_t r;
    int due;
    @(negedge clk);
    cyc++;
    pc_in          = pc_nxt;
    flush          = ($urandom_range(99) < p_flush);
    imem_req_ready = ($urandom_range(99) < p_ready);
    id_ready       = ($urandom_range(99) < p_idr);
    if (spur && mem_q.size() == 0) begin
      imem_rsp_valid = 1'b1;
      imem_rdata     = $urandom;
    end else if (mem_q.size() != 0 && mem_q[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rdata     = mem_data(mem_q[0].addr);
    end else begin
      imem_rsp_valid = 1'b0;
    end
    #2;
    exp_rv   = !flush && (buf_cnt + mem_q.size() < DEPTH);
    exp_fire = exp_rv && imem_req_ready;
    chk("imem_req_valid", 32'(imem_req_valid), 32'(exp_rv));
    chk("pc_write", 32'(pc_write), 32'(exp_fire));
    chk("imem_addr", imem_addr, pc_in);
    chk("next_pc", next_pc, pc_in + 32'd4);
    chk("fetch_err", 32'(fetch_err), 32'(model_err));

    pop  = (buf_cnt > 0) && id_ready && !flush;
    push = 0;
    if (imem_rsp_valid) begin
      if (mem_q.size() == 0) model_err = 1;
      else begin
        r = mem_q.pop_front();
        if (!r.stale && !flush) begin
          exp_q.push_back('{pc: r.addr, instr: mem_data(r.addr)});
          push = 1;
        end
      end
    end
    if (flush) begin
      foreach (mem_q[i]) mem_q[i].stale = 1;
      exp_q.delete();
      buf_cnt = 0;
      pc_nxt  = $urandom & 32'hFFFF_FFFC;
    end else begin
      buf_cnt = buf_cnt + int'(push) - int'(pop);
      if (exp_fire) begin
        due = cyc + $urandom_range(lat_max, 1);
        if (due <= last_due) due = last_due + 1;
        last_due = due;
        mem_q.push_back('{addr: pc_in, due: due, stale: 0});
        pc_nxt = pc_in + 32'd4;
      end
    end
  endtask

  task automatic drain();
    int n = 0;
    p_flush = 0; p_ready = 0; p_idr = 100;
    while ((mem_q.size() != 0 || buf_cnt != 0) && n < 60) begin
      step();
      n++;
    end
    total++;
    if (mem_q.size() != 0 || buf_cnt != 0) begin
      bad++;
      $display("FAIL drain_timeout: got inflight=%0d buffered=%0d want 0", mem_q.size(), buf_cnt);
    end
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_if_valid"}, 32'(if_valid), 32'd0);
    chk({tag, "_req_valid"}, 32'(imem_req_valid), 32'd0);
    chk({tag, "_pc_write"}, 32'(pc_write), 32'd0);
    chk({tag, "_if_instr"}, if_instr, 32'd0);
    chk({tag, "_if_pc"}, if_pc, 32'd0);
    chk({tag, "_fetch_err"}, 32'(fetch_err), 32'd0);
  endtask

  initial begin
    #3;
    imem_req_ready = 1'b1;
    reset_checks("rst");
    repeat (2) @(negedge clk);
    reset = 1'b1;
    imem_req_ready = 1'b0;
    mon_en = 1;

    // Streaming from 0 with a 1-cycle memory and a ready decoder.
    pc_nxt = 32'h0;
    repeat (30) step();
    // Decode stall, then release.
    p_idr = 0;   repeat (6) step();
    p_idr = 100; repeat (10) step();
    // Memory not accepting: address must hold.
    p_ready = 0;   repeat (3) step();
    p_ready = 100; repeat (5) step();
    // Random mix with flushes and multi-cycle latency.
    lat_max = 3; p_flush = 10; p_ready = 70; p_idr = 70;
    repeat (300) step();
    drain();
    // Address wrap.
    pc_nxt = 32'hFFFF_FFF0; p_ready = 100; p_idr = 100; lat_max = 1;
    repeat (12) step();
    drain();
    // Spurious response sets sticky error.
    spur = 1; step(); spur = 0;
    repeat (3) step();
    chk("err_sticky", 32'(fetch_err), 32'd1);
    // Mid-operation reset clears everything.
    mon_en = 0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    reset_checks("midrst");
    mem_q.delete(); exp_q.delete(); buf_cnt = 0; model_err = 0; last_due = cyc;
    @(negedge clk);
    reset = 1'b1;
    mon_en = 1;
    lat_max = 2; p_flush = 5; p_ready = 80; p_idr = 80;
    repeat (60) step();
    drain();
    mon_en = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end
endmodule
